// File: rtl/hot_page_push_pkg.sv
// rtl/hot_page_push_pkg.sv - shared state encoding and page constants for hot-page migration
package hot_page_push_pkg;

    localparam int PAGE_SHIFT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } mig_state_e;

    function automatic logic [63:0] page_align(input logic [63:0] addr);
        return {addr[63:PAGE_SHIFT], {PAGE_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/hot_page_mig_chan.sv
// rtl/hot_page_mig_chan.sv - one copy channel: slot latch, issue pointer with empty-slot skip, outstanding count
module hot_page_mig_chan
    import hot_page_push_pkg::*;
#(
    parameter int CH_SLOTS = 8,
    localparam int PW      = $clog2(CH_SLOTS + 1)
) (
    input  logic                       axi4_mm_clk,
    input  logic                       axi4_mm_rst,
    input  logic                       load,
    input  logic                       issue_en,
    input  logic [CH_SLOTS-1:0][63:0]  src_addr,
    input  logic [CH_SLOTS-1:0][63:0]  dst_addr,
    output logic                       req_valid,
    output logic [63:0]                req_src,
    output logic [63:0]                req_dst,
    input  logic                       req_ready,
    input  logic                       done,
    output logic                       last_slot,
    output logic [PW-1:0]              outstanding_nxt
);

    logic [CH_SLOTS-1:0][63:0] src_q;
    logic [CH_SLOTS-1:0][63:0] dst_q;
    logic [PW-1:0]             ptr;
    logic [PW-1:0]             outstanding;
    logic [63:0]               cur_src;
    logic [63:0]               cur_dst;
    logic                      at_end;
    logic                      slot_empty;
    logic                      advance;
    logic                      hs;
    logic                      dn;

    always_comb begin
        cur_src = '0;
        cur_dst = '0;
        for (int i = 0; i < CH_SLOTS; i++) begin
            if (ptr == PW'(i)) begin
                cur_src = src_q[i];
                cur_dst = dst_q[i];
            end
        end
    end

    assign at_end     = (ptr == PW'(CH_SLOTS));
    assign slot_empty = (cur_src == '0);
    assign req_valid  = issue_en & ~at_end & ~slot_empty;
    assign req_src    = page_align(cur_src);
    assign req_dst    = page_align(cur_dst);
    assign hs         = req_valid & req_ready;
    assign advance    = issue_en & ~at_end & (slot_empty | req_ready);
    // Asserted in the cycle the pointer steps past the final slot, so the FSM leaves ISSUE without an idle cycle
    assign last_slot  = at_end | (advance & (ptr == PW'(CH_SLOTS - 1)));
    assign dn         = done & (outstanding != '0);

    always_comb begin
        outstanding_nxt = outstanding;
        if (hs && !dn) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (dn && !hs) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            src_q       <= '0;
            dst_q       <= '0;
            ptr         <= '0;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (load) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                ptr   <= '0;
            end else if (advance) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hot_page_mig_dispatcher.sv
// rtl/hot_page_mig_dispatcher.sv - dispatches a latched page group over two copy channels; HPPB_MIG_DISPATCH_TIMEOUT_EN adds a DRAIN timeout
module hot_page_mig_dispatcher
    import hot_page_push_pkg::*;
#(
    parameter int MIG_GRP_SIZE = 16,
    parameter int CH_SLOTS     = MIG_GRP_SIZE / 2
) (
    input  logic                       axi4_mm_clk,
    input  logic                       axi4_mm_rst,
    input  logic                       new_addr_available,
    input  logic [CH_SLOTS-1:0][63:0]  src_addr,
    input  logic [CH_SLOTS-1:0][63:0]  dst_addr,
    input  logic [CH_SLOTS-1:0][63:0]  src_addr1,
    input  logic [CH_SLOTS-1:0][63:0]  dst_addr1,
    output logic                       cp0_req_valid,
    output logic [63:0]                cp0_req_src,
    output logic [63:0]                cp0_req_dst,
    input  logic                       cp0_req_ready,
    input  logic                       cp0_done,
    output logic                       cp1_req_valid,
    output logic [63:0]                cp1_req_src,
    output logic [63:0]                cp1_req_dst,
    input  logic                       cp1_req_ready,
    input  logic                       cp1_done,
    output logic                       busy,
    output logic [63:0]                mig_done_cnt,
`ifdef HPPB_MIG_DISPATCH_TIMEOUT_EN
    output logic                       mig_timeout,
`endif
    output logic [31:0]                grp_drop_cnt
);

    localparam int PW = $clog2(CH_SLOTS + 1);

    mig_state_e    state;
    logic          load;
    logic          issue_en;
    logic          last0;
    logic          last1;
    logic [PW-1:0] onxt0;
    logic [PW-1:0] onxt1;
`ifdef HPPB_MIG_DISPATCH_TIMEOUT_EN
    logic [15:0]   drain_cyc;
`endif

    assign load     = (state == ST_IDLE) & new_addr_available;
    assign issue_en = (state == ST_ISSUE);
    assign busy     = (state != ST_IDLE);

    hot_page_mig_chan #(.CH_SLOTS(CH_SLOTS)) u_ch0 (
        .axi4_mm_clk(axi4_mm_clk), .axi4_mm_rst(axi4_mm_rst),
        .load(load), .issue_en(issue_en),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .req_valid(cp0_req_valid), .req_src(cp0_req_src), .req_dst(cp0_req_dst),
        .req_ready(cp0_req_ready), .done(cp0_done),
        .last_slot(last0), .outstanding_nxt(onxt0)
    );

    hot_page_mig_chan #(.CH_SLOTS(CH_SLOTS)) u_ch1 (
        .axi4_mm_clk(axi4_mm_clk), .axi4_mm_rst(axi4_mm_rst),
        .load(load), .issue_en(issue_en),
        .src_addr(src_addr1), .dst_addr(dst_addr1),
        .req_valid(cp1_req_valid), .req_src(cp1_req_src), .req_dst(cp1_req_dst),
        .req_ready(cp1_req_ready), .done(cp1_done),
        .last_slot(last1), .outstanding_nxt(onxt1)
    );

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state        <= ST_IDLE;
            mig_done_cnt <= '0;
            grp_drop_cnt <= '0;
`ifdef HPPB_MIG_DISPATCH_TIMEOUT_EN
            drain_cyc    <= '0;
            mig_timeout  <= 1'b0;
`endif
        end else begin
            if (new_addr_available && state != ST_IDLE && grp_drop_cnt != '1) begin
                grp_drop_cnt <= grp_drop_cnt + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (new_addr_available) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (last0 && last1) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Look at next-cycle outstanding so the count moves the cycle after the final done
                    if (onxt0 == '0 && onxt1 == '0) begin
                        state        <= ST_IDLE;
                        mig_done_cnt <= mig_done_cnt + 64'd1;
`ifdef HPPB_MIG_DISPATCH_TIMEOUT_EN
                    end else if (drain_cyc == 16'hFFFF) begin
                        state        <= ST_IDLE;
                        mig_done_cnt <= mig_done_cnt + 64'd1;
                        mig_timeout  <= 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef HPPB_MIG_DISPATCH_TIMEOUT_EN
            drain_cyc <= (state == ST_DRAIN) ? drain_cyc + 16'd1 : 16'd0;
`endif
        end
    end

endmodule

// File: doc/hot_page_mig_dispatcher.md
HOT_PAGE_MIG_DISPATCHER -- requirements
Module: hot_page_mig_dispatcher

Interface
REQ-001 SHALL have parameter MIG_GRP_SIZE, default 16, pages per migration group (even, >=2).
REQ-002 SHALL have parameter CH_SLOTS, default MIG_GRP_SIZE/2, slots per copy channel.
REQ-003 axi4_mm_clk  input  1  sole clock; all logic on rising edge.
REQ-004 axi4_mm_rst  input  1  synchronous, active-high reset.
REQ-005 new_addr_available  input  1  one-cycle group-valid strobe from the address handler.
REQ-006 src_addr, dst_addr  input  64 x CH_SLOTS  channel-0 page pairs; src==0 marks an empty slot.
REQ-007 src_addr1, dst_addr1  input  64 x CH_SLOTS  channel-1 page pairs, same encoding.
REQ-008 cp0_req_valid / cp1_req_valid  output  1  per-channel copy request valid.
REQ-009 cp0_req_src, cp0_req_dst / cp1_req_src, cp1_req_dst  output  64  4 KB-aligned page addresses.
REQ-010 cp0_req_ready / cp1_req_ready  input  1  copy engine accepts request.
REQ-011 cp0_done / cp1_done  input  1  one-cycle pulse: one page copy finished on that channel.
REQ-012 busy  output  1  group latched and not yet retired.
REQ-013 mig_done_cnt  output  64  count of retired groups.
REQ-014 grp_drop_cnt  output  32  strobes ignored while busy (saturating).

Function
- REQ-015 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- REQ-016 In IDLE, new_addr_available SHALL latch all 4*CH_SLOTS addresses and enter ISSUE the next cycle.
- REQ-017 The first request SHALL assert cpX_req_valid in the cycle after the strobe (1-cycle latency).
- REQ-018 Each channel SHALL own an issue pointer 0..CH_SLOTS-1 that advances on valid&ready or when the current slot is empty.
- REQ-019 Empty slots SHALL be skipped at one slot per cycle without asserting valid.
- REQ-020 Valid, src and dst SHALL stay stable until ready; valid SHALL NOT drop without a handshake.
- REQ-021 Channels SHALL issue independently; no ordering is enforced between channels.
- REQ-022 Each channel SHALL keep an outstanding counter of width clog2(CH_SLOTS+1): +1 on handshake, -1 on done, unchanged when both occur in the same cycle.
- REQ-023 A done pulse while outstanding==0 SHALL be ignored.
- REQ-024 The FSM SHALL move ISSUE -> DRAIN once both pointers have passed the last slot.
- REQ-025 DRAIN -> IDLE SHALL occur when both outstanding counters are 0.
- REQ-026 On that transition mig_done_cnt SHALL increment by 1, visible the cycle after the last done.
- REQ-027 An all-empty group SHALL retire within CH_SLOTS+2 cycles and still increment mig_done_cnt.
- REQ-028 new_addr_available while busy SHALL be ignored and SHALL increment grp_drop_cnt, saturating at all-ones.
- REQ-029 A strobe in the same cycle as retirement SHALL be dropped, because busy is still high that cycle.
- REQ-030 mig_done_cnt SHALL wrap modulo 2^64.
- REQ-031 busy SHALL be high in ISSUE and DRAIN only.

Reset
- REQ-032 Reset SHALL force IDLE; all valids 0; request addresses 0; pointers, outstanding counters, busy, mig_done_cnt and grp_drop_cnt 0.
- REQ-033 Reset mid-group SHALL abandon the group; later done pulses are discarded by REQ-023.

Configuration
- REQ-034 Macro HPPB_MIG_DISPATCH_TIMEOUT_EN compiled in SHALL add a 16-bit DRAIN cycle counter.
- REQ-035 With the macro, the counter SHALL force IDLE at 0xFFFF, increment mig_done_cnt, and set sticky output mig_timeout for the rest of operation until reset.
- REQ-036 Without the macro, the mig_timeout port and counter SHALL be absent and DRAIN SHALL wait indefinitely.

Structure
- REQ-037 The FSM state enum and the PAGE_SHIFT=12 constant SHALL reside in package hot_page_push_pkg.
- REQ-038 Per-channel pointer, skip and outstanding logic SHALL be one sub-module, hot_page_mig_chan, instantiated twice.

Verification
- REQ-039 Group with all 16 slots valid, ready always 1, done 10 cycles after each handshake -> 8 handshakes per channel on cycles 1..8; mig_done_cnt=1 one cycle after the final done.
- REQ-040 Ch0 slots 1,3,5 empty, ch1 all empty -> 5 requests on ch0 and 0 on ch1; retirement after 5 dones.
- REQ-041 cp0_req_ready held 0 for 20 cycles -> valid and addresses stable for all 20 cycles; first handshake on cycle 21.
- REQ-042 Second strobe 3 cycles after the first -> grp_drop_cnt=1 and exactly one group is retired.
- REQ-043 done and handshake in the same cycle with outstanding=1 -> outstanding stays 1.
- REQ-044 Reset asserted in DRAIN with 4 outstanding -> IDLE next cycle, busy=0, mig_done_cnt=0, and following done pulses have no effect.
